// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter slice.
// Holds the owner/state enums, the access-size encodings and the request-field
// struct carried from a requester to the shared master port.
package sram_like_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Request fields that follow the winner/owner onto the master port.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like bus: request fields out of the requester, handshakes and read data back.
// master modport: the side that issues requests (drives req/wr/size/addr/wdata).
// slave modport:  the side that answers them (drives rdata/addr_ok/data_ok).
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter_prio_pick.sv
// Picks the winner between inst and data requests: data first, inst forced after
// STARVE_LIMIT consecutive losses. Ports: clk/rst, i_grant_en (arbiter idle),
// i_inst_req/i_data_req in; o_grant_vld/o_grant_owner out (combinational).
module sram_like_prio_pick
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_grant_en,
  input  logic   i_inst_req,
  input  logic   i_data_req,
  output logic   o_grant_vld,
  output owner_e o_grant_owner
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_inst;
  logic             w_data_win;
  logic             w_inst_win;

  // A limit of 0 disables forcing, giving strict data priority.
  assign w_force_inst = i_inst_req && (r_starve_cnt == LIMIT) && (STARVE_LIMIT != 0);
  assign w_data_win   = i_data_req && !w_force_inst;
  assign w_inst_win   = !w_data_win && i_inst_req;

  assign o_grant_vld   = w_data_win || w_inst_win;
  assign o_grant_owner = w_data_win ? OWN_DATA : OWN_INST;

  // Counts only grant cycles in which inst was actually waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant_en) begin
      if (w_inst_win) begin
        r_starve_cnt <= '0;
      end else if (w_data_win && i_inst_req && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between inst and data requesters, one
// transaction outstanding. Ports: clk, rst (sync, high), inst_bus/data_bus (slave
// modports), m_bus (master modport), busy (state != IDLE).
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  sram_like_if.slave  inst_bus,
  sram_like_if.slave  data_bus,
  sram_like_if.master m_bus,
  output logic        busy
);

  state_e      r_state;
  state_e      w_state_nxt;
  owner_e      r_owner;
  owner_e      w_owner_nxt;

  logic        w_idle;
  logic        w_grant_vld;
  owner_e      w_grant_owner;
  owner_e      w_sel_owner;
  logic        w_sel_vld;
  logic        w_m_req;
  logic        w_addr_ok_fwd;
  logic        w_data_ok_fwd;
  req_fields_t w_inst_f;
  req_fields_t w_data_f;
  req_fields_t w_m_f;

  assign w_idle = (r_state == IDLE);

  sram_like_prio_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .clk           (clk),
    .rst           (rst),
    .i_grant_en    (w_idle),
    .i_inst_req    (inst_bus.req),
    .i_data_req    (data_bus.req),
    .o_grant_vld   (w_grant_vld),
    .o_grant_owner (w_grant_owner)
  );

  // In IDLE the fresh grant drives the port with zero latency; afterwards the
  // locked owner does, so a late-arriving request cannot disturb a held one.
  assign w_sel_owner = w_idle ? w_grant_owner : r_owner;
  assign w_sel_vld   = w_idle ? w_grant_vld   : 1'b1;
  assign w_m_req     = w_idle ? w_grant_vld   : (r_state == ADDR);

  assign w_inst_f = '{wr: inst_bus.wr, size: inst_bus.size, addr: inst_bus.addr, wdata: inst_bus.wdata};
  assign w_data_f = '{wr: data_bus.wr, size: data_bus.size, addr: data_bus.addr, wdata: data_bus.wdata};

  always_comb begin
    w_m_f = '0;
    if (w_sel_vld) begin
      w_m_f = (w_sel_owner == OWN_DATA) ? w_data_f : w_inst_f;
    end
  end

  assign m_bus.req   = w_m_req;
  assign m_bus.wr    = w_m_f.wr;
  assign m_bus.size  = w_m_f.size;
  assign m_bus.addr  = w_m_f.addr;
  assign m_bus.wdata = w_m_f.wdata;

  // addr_ok only counts while a request is on the port. data_ok counts either in
  // DATA, or together with addr_ok on the request cycle; anything else is stray.
  assign w_addr_ok_fwd = w_m_req && m_bus.addr_ok;
  assign w_data_ok_fwd = (w_addr_ok_fwd && m_bus.data_ok) ||
                         ((r_state == DATA) && m_bus.data_ok);

  assign inst_bus.addr_ok = w_addr_ok_fwd && (w_sel_owner == OWN_INST);
  assign data_bus.addr_ok = w_addr_ok_fwd && (w_sel_owner == OWN_DATA);
  assign inst_bus.data_ok = w_data_ok_fwd && (w_sel_owner == OWN_INST);
  assign data_bus.data_ok = w_data_ok_fwd && (w_sel_owner == OWN_DATA);

  assign inst_bus.rdata = m_bus.rdata;
  assign data_bus.rdata = m_bus.rdata;

  assign busy = !w_idle;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_owner_nxt = w_grant_owner;
          if (m_bus.addr_ok && m_bus.data_ok) begin
            w_state_nxt = IDLE;
          end else if (m_bus.addr_ok) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = ADDR;
          end
        end
      end
      ADDR: begin
        if (m_bus.addr_ok && m_bus.data_ok) begin
          w_state_nxt = IDLE;
        end else if (m_bus.addr_ok) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (m_bus.data_ok) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_DATA;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with STARVE_LIMIT=4.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expected values are hand-derived constants for each step.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   bad;

  sram_like_if inst_bus ();
  sram_like_if data_bus ();
  sram_like_if m_bus ();

  sram_like_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_bus (inst_bus),
    .data_bus (data_bus),
    .m_bus    (m_bus),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected grant order with both sides requesting every cycle: 1 = data, 0 = inst.
  logic [9:0] exp_order;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = SIZE_WORD;
    inst_bus.addr = '0;  inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = SIZE_WORD;
    data_bus.addr = '0;  data_bus.wdata = '0;
    m_bus.rdata = '0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0;

    // Reset state
    next_cyc; next_cyc; settle;
    chk("rst_busy",      {31'd0, busy},             32'd0);
    chk("rst_m_req",     {31'd0, m_bus.req},        32'd0);
    chk("rst_i_addr_ok", {31'd0, inst_bus.addr_ok}, 32'd0);
    chk("rst_d_addr_ok", {31'd0, data_bus.addr_ok}, 32'd0);
    chk("rst_i_data_ok", {31'd0, inst_bus.data_ok}, 32'd0);
    chk("rst_d_data_ok", {31'd0, data_bus.data_ok}, 32'd0);

    // Single data read: addr_ok cycle 1, data_ok cycle 3
    next_cyc; rst = 1'b0;
    data_bus.req = 1'b1; data_bus.addr = 32'h0000_1000; settle;
    chk("t1_c0_m_req",   {31'd0, m_bus.req},        32'd1);
    chk("t1_c0_m_addr",  m_bus.addr,                32'h0000_1000);
    chk("t1_c0_busy",    {31'd0, busy},             32'd0);
    chk("t1_c0_d_aok",   {31'd0, data_bus.addr_ok}, 32'd0);
    next_cyc; m_bus.addr_ok = 1'b1; settle;
    chk("t1_c1_busy",    {31'd0, busy},             32'd1);
    chk("t1_c1_d_aok",   {31'd0, data_bus.addr_ok}, 32'd1);
    chk("t1_c1_i_aok",   {31'd0, inst_bus.addr_ok}, 32'd0);
    next_cyc; m_bus.addr_ok = 1'b0; data_bus.req = 1'b0; settle;
    chk("t1_c2_m_req",   {31'd0, m_bus.req},        32'd0);
    chk("t1_c2_d_dok",   {31'd0, data_bus.data_ok}, 32'd0);
    next_cyc; m_bus.data_ok = 1'b1; m_bus.rdata = 32'hDEAD_BEEF; settle;
    chk("t1_c3_d_dok",   {31'd0, data_bus.data_ok}, 32'd1);
    chk("t1_c3_d_rdata", data_bus.rdata,            32'hDEAD_BEEF);
    chk("t1_c3_i_dok",   {31'd0, inst_bus.data_ok}, 32'd0);
    chk("t1_c3_i_aok",   {31'd0, inst_bus.addr_ok}, 32'd0);
    next_cyc; m_bus.data_ok = 1'b0; settle;
    chk("t1_c4_busy",    {31'd0, busy},             32'd0);
    chk("t1_c4_d_dok",   {31'd0, data_bus.data_ok}, 32'd0);

    // Simultaneous requests: data wins, inst waits until data completes
    next_cyc;
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000;
    data_bus.req = 1'b1; data_bus.addr = 32'h0000_2000;
    m_bus.addr_ok = 1'b1; settle;
    chk("t2_c0_m_addr",  m_bus.addr,                32'h0000_2000);
    chk("t2_c0_d_aok",   {31'd0, data_bus.addr_ok}, 32'd1);
    chk("t2_c0_i_aok",   {31'd0, inst_bus.addr_ok}, 32'd0);
    next_cyc; data_bus.req = 1'b0; settle;   // stray addr_ok while m_req=0
    chk("t2_c1_m_req",   {31'd0, m_bus.req},        32'd0);
    chk("t2_c1_i_aok",   {31'd0, inst_bus.addr_ok}, 32'd0);
    chk("t2_c1_busy",    {31'd0, busy},             32'd1);
    next_cyc; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b1; settle;
    chk("t2_c2_d_dok",   {31'd0, data_bus.data_ok}, 32'd1);
    chk("t2_c2_i_dok",   {31'd0, inst_bus.data_ok}, 32'd0);
    next_cyc; m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1; settle;
    chk("t2_c3_m_addr",  m_bus.addr,                32'hBFC0_0000);
    chk("t2_c3_i_aok",   {31'd0, inst_bus.addr_ok}, 32'd1);
    chk("t2_c3_i_dok",   {31'd0, inst_bus.data_ok}, 32'd1);
    next_cyc; inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; settle;
    chk("t2_c4_busy",    {31'd0, busy},             32'd0);

    // Both requesting continuously against a 1-cycle slave: D,D,D,D,I,D,D,D,D,I
    exp_order = 10'b11110_11110;
    next_cyc;
    inst_bus.req = 1'b1; data_bus.req = 1'b1;
    m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("t3_g%0d_d_aok", i), {31'd0, data_bus.addr_ok}, {31'd0, exp_order[9-i]});
      chk($sformatf("t3_g%0d_i_aok", i), {31'd0, inst_bus.addr_ok}, {31'd0, !exp_order[9-i]});
      next_cyc;
    end
    inst_bus.req = 1'b0; data_bus.req = 1'b0;
    m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; settle;
    chk("t3_end_busy", {31'd0, busy}, 32'd0);

    // Inst word fetch with addr_ok and data_ok in the same cycle
    next_cyc;
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; inst_bus.size = SIZE_WORD;
    m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1; m_bus.rdata = 32'h3C1D_BFC0; settle;
    chk("t4_m_size",     {30'd0, m_bus.size},       {30'd0, SIZE_WORD});
    chk("t4_i_dok",      {31'd0, inst_bus.data_ok}, 32'd1);
    chk("t4_i_rdata",    inst_bus.rdata,            32'h3C1D_BFC0);
    chk("t4_d_dok",      {31'd0, data_bus.data_ok}, 32'd0);
    next_cyc; inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; settle;
    chk("t4_next_busy",  {31'd0, busy},             32'd0);
    chk("t4_next_i_dok", {31'd0, inst_bus.data_ok}, 32'd0);

    // Inst held in ADDR for 5 cycles; data request arriving mid-hold is ignored
    next_cyc;
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; inst_bus.wr = 1'b0; settle;
    chk("t5_c0_m_addr", m_bus.addr, 32'hBFC0_0000);
    for (int c = 1; c < 5; c++) begin
      next_cyc;
      if (c == 2) begin
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_3000; data_bus.wr = 1'b1;
      end
      settle;
      chk($sformatf("t5_c%0d_busy", c),   {31'd0, busy},             32'd1);
      chk($sformatf("t5_c%0d_m_addr", c), m_bus.addr,                32'hBFC0_0000);
      chk($sformatf("t5_c%0d_d_aok", c),  {31'd0, data_bus.addr_ok}, 32'd0);
    end
    next_cyc; m_bus.addr_ok = 1'b1; settle;
    chk("t5_c5_m_wr",   {31'd0, m_bus.wr},         32'd0);
    chk("t5_c5_i_aok",  {31'd0, inst_bus.addr_ok}, 32'd1);
    chk("t5_c5_d_aok",  {31'd0, data_bus.addr_ok}, 32'd0);
    next_cyc; inst_bus.req = 1'b0; m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b1; settle;
    chk("t5_c6_m_req",  {31'd0, m_bus.req},        32'd0);
    chk("t5_c6_i_dok",  {31'd0, inst_bus.data_ok}, 32'd1);
    chk("t5_c6_d_dok",  {31'd0, data_bus.data_ok}, 32'd0);
    next_cyc; m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1; settle;
    chk("t5_c7_m_addr", m_bus.addr,                32'h0000_3000);
    chk("t5_c7_m_wr",   {31'd0, m_bus.wr},         32'd1);
    chk("t5_c7_d_dok",  {31'd0, data_bus.data_ok}, 32'd1);
    next_cyc; data_bus.req = 1'b0; data_bus.wr = 1'b0;
    m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; settle;
    chk("t5_c8_busy",   {31'd0, busy},             32'd0);

    // Reset in DATA, then a stray data_ok
    next_cyc;
    data_bus.req = 1'b1; data_bus.addr = 32'h0000_4000; m_bus.addr_ok = 1'b1; settle;
    chk("t6_c0_d_aok",  {31'd0, data_bus.addr_ok}, 32'd1);
    next_cyc; data_bus.req = 1'b0; m_bus.addr_ok = 1'b0; settle;
    chk("t6_c1_busy",   {31'd0, busy},             32'd1);
    next_cyc; rst = 1'b1; settle;
    next_cyc; rst = 1'b0; m_bus.data_ok = 1'b1; settle;
    chk("t6_c3_busy",   {31'd0, busy},             32'd0);
    chk("t6_c3_d_dok",  {31'd0, data_bus.data_ok}, 32'd0);
    chk("t6_c3_i_dok",  {31'd0, inst_bus.data_ok}, 32'd0);
    next_cyc; m_bus.data_ok = 1'b0; settle;
    chk("t6_c4_busy",   {31'd0, busy},             32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
